// File: rtl/seq_addsub_pkg.sv
// rtl/seq_addsub_pkg.sv - shared types and constants for the digit-serial adder/subtractor
// Contents: state_e (FSM states), MODE_ADD / MODE_SUB operation encodings.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/ripple_digit_adder.sv
// rtl/ripple_digit_adder.sv - combinational DIGIT-bit ripple-carry adder slice
// Ports: a, b (DIGIT-bit addends), c_in (carry in), sum (DIGIT-bit result),
//        c_msb_in (carry into the top bit, for signed overflow), c_out (carry out).
module ripple_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_msb_in,
  output logic             c_out
);

  logic c;

  always_comb begin
    c        = c_in;
    c_msb_in = 1'b0;
    sum      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock, LSD first
// Ports: clk, rst_n (async active-low); start, mode (0 add / 1 sub), a, b, c_in in;
//        busy, done (1-cycle pulse), sum, c_out (sub: 1 = no borrow), ovf, zero out.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_param_check
    $error("seq_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;

  logic [DIGIT-1:0] d_sum;
  logic             d_cmsb;
  logic             d_cout;
  logic             last_digit;

  // Operands shift right each cycle, so the current digit is always at the bottom.
  ripple_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .c_in     (carry_q),
    .sum      (d_sum),
    .c_msb_in (d_cmsb),
    .c_out    (d_cout)
  );

  assign last_digit = (cnt_q == LAST_CNT);

  // Result assembled in place; on the final digit this is the complete sum.
  always_comb begin
    res_next = res_q;
    res_next[int'(cnt_q) * DIGIT +: DIGIT] = d_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= d_cout;
          if (last_digit) begin
            cnt_q   <= '0;
            sum     <= res_next;
            c_out   <= d_cout;
            ovf     <= d_cmsb ^ d_cout;
            zero    <= (res_next == '0);
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving bubble-free back-to-back ops.
          if (start) begin
            a_q     <= a;
            b_q     <= (mode == MODE_SUB) ? ~b : b;
            carry_q <= (mode == MODE_ADD) ? c_in : 1'b1;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - self-checking bench for seq_addsub at DIGIT = 1, 4 and 8 (WIDTH = 8)
module tb_seq_addsub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;

  logic       busy_w [3];
  logic       done_w [3];
  logic [7:0] sum_w  [3];
  logic       cout_w [3];
  logic       ovf_w  [3];
  logic       zero_w [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    seq_addsub #(.WIDTH(8), .DIGIT(DG)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .sum   (sum_w[g]),
      .c_out (cout_w[g]),
      .ovf   (ovf_w[g]),
      .zero  (zero_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ncyc(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 1;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic m, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       output logic [7:0] es, output logic ec, output logic eo, output logic ez);
    int ua, ub, sa, sb, ru, rs;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (m) begin
      ru = ua - ub;
      rs = sa - sb;
      ec = (ua >= ub);
    end else begin
      ru = ua + ub + int'(ci);
      rs = sa + sb + int'(ci);
      ec = (ru > 255);
    end
    es = ru[7:0];
    eo = (rs < -128) || (rs > 127);
    ez = (es == 8'h00);
  endtask

  task automatic check_res(input int i, input string nm, input logic [7:0] es, input logic ec,
                           input logic eo, input logic ez);
    check8($sformatf("%s d%0d sum", nm, i), sum_w[i], es);
    check1($sformatf("%s d%0d c_out", nm, i), cout_w[i], ec);
    check1($sformatf("%s d%0d ovf", nm, i), ovf_w[i], eo);
    check1($sformatf("%s d%0d zero", nm, i), zero_w[i], ez);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on all three DUTs; checks busy/done timing each cycle and
  // that results appear on the done cycle and hold afterwards.
  task automatic run_op(input logic m, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input string nm);
    logic [7:0] es;
    logic ec, eo, ez;
    model(m, av, bv, ci, es, ec, eo, ez);
    mode  = m;
    a     = av;
    b     = bv;
    c_in  = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 3; i++) begin
        check1($sformatf("%s d%0d busy e%0d", nm, i, j), busy_w[i], j < ncyc(i));
        check1($sformatf("%s d%0d done e%0d", nm, i, j), done_w[i], j == ncyc(i));
        if (j >= ncyc(i)) check_res(i, nm, es, ec, eo, ez);
      end
      tick();
    end
  endtask

  initial begin
    logic [7:0] es;
    logic ec, eo, ez;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("reset d%0d busy", i), busy_w[i], 1'b0);
      check1($sformatf("reset d%0d done", i), done_w[i], 1'b0);
      check_res(i, "reset", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    tick();

    // Directed vectors
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, "add5a3c");
    run_op(1'b0, 8'hFF, 8'h01, 1'b1, "addcin");
    run_op(1'b1, 8'h10, 8'h20, 1'b0, "sub1020");
    run_op(1'b1, 8'h80, 8'h01, 1'b1, "sub8001");
    run_op(1'b1, 8'h80, 8'h80, 1'b0, "sub8080");
    run_op(1'b0, 8'hA7, 8'h59, 1'b0, "adda759");

    // start held high: done after edge N, then every N+1 edges
    model(1'b1, 8'h80, 8'h01, 1'b0, es, ec, eo, ez);
    mode  = 1'b1;
    a     = 8'h80;
    b     = 8'h01;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 3; i++) begin
        logic exp_done;
        exp_done = (j >= ncyc(i)) && (((j - ncyc(i)) % (ncyc(i) + 1)) == 0);
        check1($sformatf("held d%0d done e%0d", i, j), done_w[i], exp_done);
        check1($sformatf("held d%0d busy e%0d", i, j), busy_w[i], !exp_done);
        if (exp_done) check_res(i, "held", es, ec, eo, ez);
      end
      tick();
    end
    start = 1'b0;
    for (int j = 0; j < 12; j++) tick();

    // start pulsed during RUN with other operands must not disturb the DIGIT=1 operation
    model(1'b0, 8'h12, 8'h34, 1'b0, es, ec, eo, ez);
    mode  = 1'b0;
    a     = 8'h12;
    b     = 8'h34;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j == 2) begin
        start = 1'b1;
        mode  = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
      end else begin
        start = 1'b0;
      end
      check1($sformatf("pulse busy e%0d", j), busy_w[0], j < 8);
      check1($sformatf("pulse done e%0d", j), done_w[0], j == 8);
      if (j >= 8) check_res(0, "pulse", es, ec, eo, ez);
      tick();
    end
    start = 1'b0;
    for (int j = 0; j < 6; j++) tick();

    // Reset in the middle of a DIGIT=1 operation
    mode  = 1'b0;
    a     = 8'h5A;
    b     = 8'h3C;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("midrst d%0d busy", i), busy_w[i], 1'b0);
      check1($sformatf("midrst d%0d done", i), done_w[i], 1'b0);
      check_res(i, "midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check1($sformatf("postrst done e%0d", j), done_w[0], 1'b0);
      check1($sformatf("postrst busy e%0d", j), busy_w[0], 1'b0);
      tick();
    end
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, "afterrst");

    // Random sweep
    for (int k = 0; k < 1000; k++) begin
      logic       rm, rc;
      logic [7:0] ra, rb;
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(rm, ra, rb, rc, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
